// File: rtl/ram_1port_bwe.sv
// Single-port synchronous RAM model with byte-lane write enables, a req/ready/valid handshake
// and 1- or 2-cycle read latency. Define RAM_1PORT_BWE_INIT_CLR_EN to add the post-reset clear sequencer.
module ram_1port_bwe #(
  parameter int                  ADR_BIT  = 4,
  parameter int                  DAT_BIT  = 32,
  parameter int                  WEN_BIT  = 4,
  parameter int                  RD_LAT   = 1,
  parameter logic [DAT_BIT-1:0]  INIT_VAL = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req,
  input  logic               we,
  input  logic [WEN_BIT-1:0] wen,
  input  logic [ADR_BIT-1:0] addr,
  input  logic [DAT_BIT-1:0] w_data,
  output logic               ready,
  output logic [DAT_BIT-1:0] r_data,
  output logic               r_valid
);

  localparam int LANE_W = DAT_BIT / WEN_BIT;
  localparam int DEPTH  = 1 << ADR_BIT;

  if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_rd_lat
    $fatal(1, "ram_1port_bwe: RD_LAT must be 1 or 2");
  end
  if (DAT_BIT % WEN_BIT != 0) begin : g_bad_lanes
    $fatal(1, "ram_1port_bwe: DAT_BIT must be a multiple of WEN_BIT");
  end

  function automatic logic [DAT_BIT-1:0] lane_merge(input logic [DAT_BIT-1:0] old_w,
                                                    input logic [DAT_BIT-1:0] new_w,
                                                    input logic [WEN_BIT-1:0] en);
    logic [DAT_BIT-1:0] res;
    res = old_w;
    for (int i = 0; i < WEN_BIT; i++) begin
      if (en[i]) res[i*LANE_W +: LANE_W] = new_w[i*LANE_W +: LANE_W];
    end
    return res;
  endfunction

  logic [DAT_BIT-1:0] mem_q [DEPTH];
  logic               accept;
  logic               rd_acc;
  logic               wr_acc;
  logic               clr_active;
  logic [ADR_BIT-1:0] clr_addr;

  assign accept = req & ready;
  assign rd_acc = accept & ~we;
  assign wr_acc = accept & we;

`ifdef RAM_1PORT_BWE_INIT_CLR_EN
  localparam logic [0:0]         ST_CLR   = 1'b0;
  localparam logic [0:0]         ST_IDLE  = 1'b1;
  localparam logic [ADR_BIT-1:0] LAST_ADR = '1;

  logic [0:0]         state_q, state_d;
  logic [ADR_BIT-1:0] clr_cnt_q, clr_cnt_d;

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    if (state_q == ST_CLR) begin
      clr_cnt_d = clr_cnt_q + ADR_BIT'(1);
      if (clr_cnt_q == LAST_ADR) state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_CLR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  assign ready      = (state_q == ST_IDLE);
  assign clr_active = (state_q == ST_CLR);
  assign clr_addr   = clr_cnt_q;
`else
  assign ready      = 1'b1;
  assign clr_active = 1'b0;
  assign clr_addr   = '0;
`endif

  // Array write port: the clear sequencer owns it while ready is low.
  logic               mem_we;
  logic [ADR_BIT-1:0] mem_waddr;
  logic [DAT_BIT-1:0] mem_wdata;

  always_comb begin
    mem_we    = wr_acc;
    mem_waddr = addr;
    mem_wdata = lane_merge(mem_q[addr], w_data, wen);
    if (clr_active) begin
      mem_we    = 1'b1;
      mem_waddr = clr_addr;
      mem_wdata = INIT_VAL;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  // Stage p0: array read registered at the accept edge.
  logic               rd_vld_p0_q, rd_vld_p0_d;
  logic [DAT_BIT-1:0] rd_data_p0_q, rd_data_p0_d;

  always_comb begin
    rd_vld_p0_d  = rd_acc;
    rd_data_p0_d = rd_acc ? mem_q[addr] : rd_data_p0_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld_p0_q  <= 1'b0;
      rd_data_p0_q <= '0;
    end else begin
      rd_vld_p0_q  <= rd_vld_p0_d;
      rd_data_p0_q <= rd_data_p0_d;
    end
  end

  if (RD_LAT == 2) begin : g_lat2
    // Stage p1: extra output register, holds its data between reads.
    logic               rd_vld_p1_q, rd_vld_p1_d;
    logic [DAT_BIT-1:0] rd_data_p1_q, rd_data_p1_d;

    always_comb begin
      rd_vld_p1_d  = rd_vld_p0_q;
      rd_data_p1_d = rd_vld_p0_q ? rd_data_p0_q : rd_data_p1_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd_vld_p1_q  <= 1'b0;
        rd_data_p1_q <= '0;
      end else begin
        rd_vld_p1_q  <= rd_vld_p1_d;
        rd_data_p1_q <= rd_data_p1_d;
      end
    end

    assign r_valid = rd_vld_p1_q;
    assign r_data  = rd_data_p1_q;
  end else begin : g_lat1
    assign r_valid = rd_vld_p0_q;
    assign r_data  = rd_data_p0_q;
  end

endmodule
